// File: rtl/hmac_pkg.sv
// Shared widths and state encoding for the HMAC message sender.
package hmac_pkg;
    localparam int MSG_W    = 32;
    localparam int DIGEST_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KICK,
        ST_SEND,
        ST_WAIT_DONE
    } sender_state_e;
endpackage

// File: rtl/hmac_msg_buffer.sv
// Message word register file: one write port, one combinational read port.
module hmac_msg_buffer
    import hmac_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [MSG_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [MSG_W-1:0] rdata_o
);
    logic [MSG_W-1:0] mem_q [DEPTH];

    // Storage is never reset; entries at or above count are don't-care.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/hmac_msg_sender.sv
// Buffers a message and streams it to an HMAC engine, then captures the tag.
module hmac_msg_sender
    import hmac_pkg::*;
#(
    parameter int MAX_WORDS = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [MSG_W-1:0]    wr_data,
    output logic                wr_full,
    input  logic                clear,
    input  logic                start,
    input  logic [DIGEST_W-1:0] expect_tag,
    output logic                start_hmac,
    output logic [MSG_W-1:0]    msg_word,
    output logic                msg_valid,
    output logic                msg_last,
    input  logic                msg_ready,
    input  logic                hmac_done,
    input  logic [DIGEST_W-1:0] hmac_value,
    output logic [DIGEST_W-1:0] tag_out,
    output logic                tag_valid,
    output logic                tag_match,
    output logic                busy,
    output logic                error
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_WORDS);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    sender_state_e    state_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [TW-1:0]    timer_q;
    logic [CW-1:0]    nxt_idx_d;
    logic [AW-1:0]    rd_addr_d;
    logic [MSG_W-1:0] rd_word;
    logic             wr_ok;

    assign wr_full   = (count_q == FULL_CNT);
    assign busy      = (state_q != ST_IDLE);
    assign tag_match = tag_valid & (tag_out == expect_tag);

    assign wr_ok = wr_en & ~clear & ~wr_full
                 & (state_q == ST_IDLE);

    // Pre-fetch the word that will be on the bus after the next edge.
    assign nxt_idx_d = (state_q == ST_SEND)
                     ? {1'b0, rd_ptr_q} + CW'(1)
                     : '0;
    assign rd_addr_d = nxt_idx_d[AW-1:0];

    hmac_msg_buffer #(
        .DEPTH (MAX_WORDS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            timer_q    <= '0;
            start_hmac <= 1'b0;
            msg_valid  <= 1'b0;
            msg_last   <= 1'b0;
            msg_word   <= '0;
            tag_out    <= '0;
            tag_valid  <= 1'b0;
            error      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_ok) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (clear) begin
                        count_q   <= '0;
                        tag_valid <= 1'b0;
                        error     <= 1'b0;
                    end else if (start) begin
                        if (count_q != '0) begin
                            state_q    <= ST_KICK;
                            start_hmac <= 1'b1;
                            tag_valid  <= 1'b0;
                            error      <= 1'b0;
                            rd_ptr_q   <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_KICK: begin
                    start_hmac <= 1'b0;
                    state_q    <= ST_SEND;
                    msg_valid  <= 1'b1;
                    msg_word   <= rd_word;
                    msg_last   <= (count_q == CW'(1));
                end
                ST_SEND: begin
                    if (msg_ready) begin
                        if (msg_last) begin
                            state_q   <= ST_WAIT_DONE;
                            msg_valid <= 1'b0;
                            msg_last  <= 1'b0;
                            timer_q   <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            msg_word <= rd_word;
                            msg_last <= (nxt_idx_d + CW'(1) == count_q);
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (hmac_done) begin
                        tag_out   <= hmac_value;
                        tag_valid <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (timer_q == TMR_LAST) begin
                        error   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hmac_msg_sender.sv
// Directed and randomized checks of hmac_msg_sender against a queue model.
module tb_hmac_msg_sender;
    localparam int MAXW = 32;
    localparam int TMO  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [31:0]  wr_data;
    logic         wr_full;
    logic         clear;
    logic         start;
    logic [511:0] expect_tag;
    logic         start_hmac;
    logic [31:0]  msg_word;
    logic         msg_valid;
    logic         msg_last;
    logic         msg_ready;
    logic         hmac_done;
    logic [511:0] hmac_value;
    logic [511:0] tag_out;
    logic         tag_valid;
    logic         tag_match;
    logic         busy;
    logic         error;

    hmac_msg_sender #(
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .clear      (clear),
        .start      (start),
        .expect_tag (expect_tag),
        .start_hmac (start_hmac),
        .msg_word   (msg_word),
        .msg_valid  (msg_valid),
        .msg_last   (msg_last),
        .msg_ready  (msg_ready),
        .hmac_done  (hmac_done),
        .hmac_value (hmac_value),
        .tag_out    (tag_out),
        .tag_valid  (tag_valid),
        .tag_match  (tag_match),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffered message, sticky error, captured tag.
    logic [31:0]  mdl[$];
    logic [31:0]  got[$];
    logic         exp_err;
    logic         exp_tv;
    logic [511:0] exp_tag;

    task automatic chkb(input string tag, input logic o, input logic e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chkt(input string tag, input logic [511:0] o,
                        input logic [511:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chki(input string tag, input int o, input int e);
        n_vec++;
        assert (o == e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rnd_tag();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en = 1'b0;
        if (mdl.size() < MAXW) mdl.push_back(w);
    endtask

    task automatic check_idle(input string tag);
        chkb({tag, "_full"}, wr_full, mdl.size() == MAXW);
        chkb({tag, "_err"}, error, exp_err);
        chkb({tag, "_tv"}, tag_valid, exp_tv);
        chkb({tag, "_busy"}, busy, 1'b0);
        chkb({tag, "_match"}, tag_match,
             exp_tv && (exp_tag == expect_tag));
    endtask

    // mode 0: always ready, 1: random ready, 2: pattern 1,0,0,1,1
    // done_dly < 0: never answer, expect the timeout
    task automatic xfer(input int mode, input int done_dly,
                        input logic [511:0] val);
        logic [31:0] prev_w;
        bit stalled, fin, r;
        int ncyc, pulses;
        int pat[5] = '{1, 0, 0, 1, 1};
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = 1'b0;
        exp_tv  = 1'b0;
        chkb("kick_pulse", start_hmac, 1'b1);
        chkb("kick_busy", busy, 1'b1);
        chkb("kick_novalid", msg_valid, 1'b0);
        tick();
        stalled = 0;
        fin     = 0;
        ncyc    = 0;
        pulses  = 0;
        prev_w  = '0;
        while (!fin && ncyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (ncyc < 5) ? 1'(pat[ncyc]) : 1'b1;
            endcase
            msg_ready = r;
            if (start_hmac) pulses++;
            if (msg_valid !== 1'b1) begin
                chkb("send_valid", msg_valid, 1'b1);
                fin = 1;
            end else begin
                if (stalled) chkw("stall_stable", msg_word, prev_w);
                if (r) begin
                    got.push_back(msg_word);
                    chkb("last_flag", msg_last,
                         got.size() == mdl.size());
                    if (msg_last || got.size() > mdl.size()) fin = 1;
                end
                stalled = !r;
                prev_w  = msg_word;
            end
            tick();
            ncyc++;
        end
        msg_ready = 1'b0;
        chki("pulse_count", pulses, 0);
        chki("stream_len", got.size(), mdl.size());
        for (int i = 0; i < got.size() && i < mdl.size(); i++)
            chkw("stream_word", got[i], mdl[i]);
        if (mode == 0) chki("throughput", ncyc, mdl.size());
        chkb("wait_novalid", msg_valid, 1'b0);
        chkb("wait_busy", busy, 1'b1);
        if (done_dly < 0) begin
            repeat (TMO - 1) tick();
            chkb("pre_timeout_err", error, 1'b0);
            chkb("pre_timeout_busy", busy, 1'b1);
            tick();
            exp_err = 1'b1;
            chkb("timeout_err", error, 1'b1);
            chkb("timeout_busy", busy, 1'b0);
            chkb("timeout_tv", tag_valid, 1'b0);
        end else begin
            repeat (done_dly) tick();
            hmac_value = val;
            hmac_done  = 1'b1;
            tick();
            hmac_done = 1'b0;
            exp_tv    = 1'b1;
            exp_tag   = val;
            chkt("tag_out", tag_out, val);
            chkb("tag_valid", tag_valid, 1'b1);
            chkb("done_busy", busy, 1'b0);
            chkb("tag_match", tag_match, val == expect_tag);
        end
    endtask

    initial begin
        logic [511:0] tv;
        logic [31:0]  w;
        int           n;
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        clear      = 1'b0;
        start      = 1'b0;
        expect_tag = '0;
        msg_ready  = 1'b0;
        hmac_done  = 1'b0;
        hmac_value = '0;
        exp_err    = 1'b0;
        exp_tv     = 1'b0;
        exp_tag    = '0;

        #12;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_valid", msg_valid, 1'b0);
        chkb("rst_last", msg_last, 1'b0);
        chkw("rst_word", msg_word, 32'h0);
        chkb("rst_kick", start_hmac, 1'b0);
        chkt("rst_tag", tag_out, '0);
        check_idle("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Start with an empty buffer flags an error and never kicks.
        start = 1'b1;
        tick();
        start   = 1'b0;
        exp_err = 1'b1;
        chkb("empty_kick", start_hmac, 1'b0);
        check_idle("empty_start");
        tick();
        chkb("empty_kick2", start_hmac, 1'b0);

        clear = 1'b1;
        tick();
        clear   = 1'b0;
        exp_err = 1'b0;
        check_idle("clear");

        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        check_idle("load3");
        expect_tag = {16{32'hA5A5A5A5}};
        xfer(0, 2, {16{32'hA5A5A5A5}});
        check_idle("after_a5");

        // Retained buffer is re-sent with a stalling sink.
        xfer(2, 0, {16{32'h5A5A5A5A}});
        check_idle("after_stall");

        hmac_value = rnd_tag();
        hmac_done  = 1'b1;
        tick();
        hmac_done = 1'b0;
        chkt("idle_done_ignored", tag_out, exp_tag);
        check_idle("idle_done");

        xfer(1, -1, '0);
        check_idle("after_timeout");

        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        mdl.delete();
        exp_err = 1'b0;
        exp_tv  = 1'b0;
        check_idle("clear_start");
        tick();
        chkb("clear_start_busy", busy, 1'b0);

        for (int i = 0; i < MAXW + 1; i++) begin
            write_word($urandom);
            chkb("fill_full", wr_full, mdl.size() == MAXW);
        end
        tv         = rnd_tag();
        expect_tag = tv;
        xfer(0, 3, tv);
        check_idle("full_xfer");

        repeat (6) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            mdl.delete();
            exp_err = 1'b0;
            exp_tv  = 1'b0;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) write_word($urandom);
            tv = rnd_tag();
            expect_tag = ($urandom_range(0, 1) == 1) ? tv : rnd_tag();
            xfer(1, $urandom_range(0, 8), tv);
            check_idle("rnd");
        end

        // Reset in the middle of a 5-word stream.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl.delete();
        for (int i = 0; i < 5; i++) write_word($urandom);
        start = 1'b1;
        tick();
        start     = 1'b0;
        msg_ready = 1'b1;
        tick();
        tick();
        w = mdl[1];
        chkw("mid_word2", msg_word, w);
        #1 reset = 1'b0;
        #1;
        chkb("mid_rst_valid", msg_valid, 1'b0);
        chkb("mid_rst_busy", busy, 1'b0);
        mdl.delete();
        exp_err = 1'b0;
        exp_tv  = 1'b0;
        exp_tag = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            tick();
            chkb("post_rst_valid", msg_valid, 1'b0);
            chkb("post_rst_busy", busy, 1'b0);
        end
        msg_ready = 1'b0;
        check_idle("post_rst");
        start = 1'b1;
        tick();
        start   = 1'b0;
        exp_err = 1'b1;
        chkb("post_rst_kick", start_hmac, 1'b0);
        check_idle("post_rst_empty");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hmac_msg_sender.md
HMAC_MSG_SENDER -- requirements
Module: hmac_msg_sender

Interface
REQ-001 Parameter: MAX_WORDS, default 32, message buffer depth in 32-bit words (power of two, 2..64).
REQ-002 Parameter: TIMEOUT, default 4096, maximum cycles to wait for hmac_done after the last word.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: wr_en  in  1  buffer write strobe.
REQ-006 Port: wr_data  in  32  message word to append.
REQ-007 Port: wr_full  out  1  buffer holds MAX_WORDS words.
REQ-008 Port: clear  in  1  empty the buffer and clear status.
REQ-009 Port: start  in  1  begin one HMAC transfer of the buffered message.
REQ-010 Port: expect_tag  in  512  reference tag for comparison.
REQ-011 Port: start_hmac  out  1  one-cycle start pulse to the HMAC engine.
REQ-012 Port: msg_word  out  32  stream word.
REQ-013 Port: msg_valid  out  1  msg_word valid.
REQ-014 Port: msg_last  out  1  final word of the message.
REQ-015 Port: msg_ready  in  1  engine accepts the word.
REQ-016 Port: hmac_done  in  1  engine result valid.
REQ-017 Port: hmac_value  in  512  engine result.
REQ-018 Port: tag_out  out  512  captured result.
REQ-019 Port: tag_valid  out  1  tag_out holds the result of the most recent transfer.
REQ-020 Port: tag_match  out  1  tag_out == expect_tag, qualified by tag_valid.
REQ-021 Port: busy  out  1  FSM not in IDLE.
REQ-022 Port: error  out  1  sticky fault flag.

Function
REQ-023 FSM states: IDLE, KICK, SEND, WAIT_DONE.
REQ-024 Buffer writes: wr_en in IDLE with count<MAX_WORDS stores wr_data at index count, then count+1; wr_en when full or not in IDLE is ignored.
REQ-025 wr_full = (count == MAX_WORDS); count width = clog2(MAX_WORDS)+1.
REQ-026 clear in IDLE: count<=0, tag_valid<=0, error<=0; clear outside IDLE is ignored.
REQ-027 start in IDLE with count>0: next cycle KICK, tag_valid<=0, error<=0, rd_ptr<=0.
REQ-028 start in IDLE with count==0: error<=1, remain in IDLE; start outside IDLE is ignored.
REQ-029 clear and start in the same IDLE cycle: clear wins, start ignored.
REQ-030 KICK: start_hmac=1 for exactly that cycle; next state SEND.
REQ-031 SEND: msg_valid=1, msg_word=buf[rd_ptr], msg_last=(rd_ptr==count-1).
REQ-032 msg_word and msg_last hold stable while msg_valid=1 and msg_ready=0.
REQ-033 A handshake (msg_valid&msg_ready) advances rd_ptr; a handshake on the last word moves to WAIT_DONE with msg_valid=0 the next cycle.
REQ-034 Full throughput: one word per cycle while msg_ready=1; a count-word message takes count handshake cycles.
REQ-035 hmac_done outside WAIT_DONE is ignored.
REQ-036 WAIT_DONE: hmac_done=1 captures hmac_value into tag_out, sets tag_valid=1, returns to IDLE.
REQ-037 WAIT_DONE: a timer counts from 0; reaching TIMEOUT without hmac_done sets error=1, returns to IDLE, tag_valid stays 0.
REQ-038 Buffer contents and count are retained after a transfer; start re-sends the identical message.
REQ-039 tag_match = tag_valid & (tag_out == expect_tag), combinational.
REQ-040 busy = (state != IDLE).

Reset
REQ-041 reset low asynchronously forces: state IDLE, count 0, rd_ptr 0, timer 0, start_hmac 0, msg_valid 0, msg_last 0, msg_word 0, tag_out 0, tag_valid 0, error 0.
REQ-042 Reset assertion mid-transfer aborts immediately; no partial stream resumes after release.
REQ-043 Buffer storage needs no reset; contents are invalid while count=0.

Structure
REQ-044 Shared package hmac_pkg holds MSG_W=32, DIGEST_W=512 and the sender state enumeration.
REQ-045 One sub-module, hmac_msg_buffer: MAX_WORDS x 32 register file, one write port, one combinational read port.

Verification
REQ-046 Load 3 words 0x11111111,0x22222222,0x33333333, start, msg_ready=1 -> start_hmac pulse 1 cycle after start; words on 3 consecutive cycles; msg_last only with 0x33333333.
REQ-047 Same load, msg_ready toggling 1,0,0,1,1 -> no word dropped or duplicated; msg_word stable in stall cycles.
REQ-048 hmac_done with hmac_value=512'hA5..A5 and expect_tag equal -> tag_out=A5..A5, tag_valid=1, tag_match=1, busy=0 next cycle; differing expect_tag -> tag_match=0.
REQ-049 start with empty buffer -> error=1, start_hmac never asserted; 33rd write with MAX_WORDS=32 -> ignored, wr_full=1.
REQ-050 TIMEOUT=16, no hmac_done -> error=1 exactly 16 cycles after WAIT_DONE entry, state IDLE.
REQ-051 reset low during SEND word 2 of 5 -> msg_valid=0 immediately; after release busy=0, count=0, no further stream.
